// File: rtl/axi_req_sched.sv
// Single-outstanding AXI3 request scheduler: arbitrates IFU fetch and LSU load/store onto one master port.
// Optional fetch anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module axi_req_sched #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_cancel,
  output logic                inst_addr_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_valid,
  output logic                inst_error,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_addr_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_data_ok,
  output logic                data_error,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t                state, state_nxt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  owner_inst, aw_done, w_done, drop;
  logic                  fetch_ok, force_fetch, grant_data, grant_inst;

  // A fetch cancelled in the same cycle it is requested is never granted.
  assign fetch_ok = inst_req & ~inst_cancel;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign force_fetch = fetch_ok && (starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!inst_req || grant_inst)
        starve_cnt <= '0;
      else if (grant_data && starve_cnt != CNT_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  assign grant_data   = (state == IDLE) & data_req & ~force_fetch;
  assign grant_inst   = (state == IDLE) & fetch_ok & ~grant_data;
  assign data_addr_ok = grant_data;
  assign inst_addr_ok = grant_inst;

  assign arvalid = (state == RD_ADDR);
  assign araddr  = addr_q;
  assign rready  = (state == RD_DATA);
  assign awvalid = (state == WR_REQ) & ~aw_done;
  assign wvalid  = (state == WR_REQ) & ~w_done;
  assign awaddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = (state == WR_RESP);

  // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_data && data_wr)       state_nxt = WR_REQ;
        else if (grant_data || grant_inst) state_nxt = RD_ADDR;
      end
      RD_ADDR: if (arready) state_nxt = RD_DATA;
      RD_DATA: if (rvalid)  state_nxt = IDLE;
      WR_REQ:  if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
      WR_RESP: if (bvalid)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the response pulses default to 0 each cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      owner_inst   <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      drop         <= 1'b0;
      inst_valid   <= 1'b0;
      inst_rdata   <= '0;
      inst_error   <= 1'b0;
      data_data_ok <= 1'b0;
      data_rdata   <= '0;
      data_error   <= 1'b0;
    end else begin
      state        <= state_nxt;
      inst_valid   <= 1'b0;
      inst_rdata   <= '0;
      inst_error   <= 1'b0;
      data_data_ok <= 1'b0;
      data_rdata   <= '0;
      data_error   <= 1'b0;

      if (grant_data || grant_inst) begin
        addr_q     <= grant_data ? data_addr : inst_addr;
        wdata_q    <= grant_data ? data_wdata : '0;
        wstrb_q    <= grant_data ? data_wstrb : '0;
        owner_inst <= grant_inst;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;

      // A cancelled fetch still completes on AXI; only its response is swallowed.
      if (state_nxt == IDLE)
        drop <= 1'b0;
      else if (owner_inst && inst_cancel && (state == RD_ADDR || state == RD_DATA))
        drop <= 1'b1;

      if (rready && rvalid) begin
        if (owner_inst) begin
          if (!(drop || inst_cancel)) begin
            inst_valid <= 1'b1;
            inst_rdata <= rdata;
            inst_error <= (rresp != 2'b00);
          end
        end else begin
          data_data_ok <= 1'b1;
          data_rdata   <= rdata;
          data_error   <= (rresp != 2'b00);
        end
      end
      if (bready && bvalid) begin
        data_data_ok <= 1'b1;
        data_error   <= (bresp != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_axi_req_sched.sv
// Self-checking bench for axi_req_sched: directed scenarios plus randomized transactions
// checked against a cycle-arithmetic model of arbitration, channel sequencing and response timing.
module tb_axi_req_sched;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit STARVE_GUARD = 1'b1;
`else
  localparam bit STARVE_GUARD = 1'b0;
`endif
  localparam int STARVE_MAX = 4;

  logic        aclk = 1'b0, areset = 1'b1;
  logic        inst_req = 0, inst_cancel = 0, inst_addr_ok, inst_valid, inst_error;
  logic [31:0] inst_addr = '0, inst_rdata;
  logic        data_req = 0, data_wr = 0, data_addr_ok, data_data_ok, data_error;
  logic [31:0] data_addr = '0, data_wdata = '0, data_rdata;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] araddr, awaddr, wdata, rdata = '0;
  logic        arvalid, arready = 0, rvalid = 0, rready;
  logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic [1:0]  rresp = '0, bresp = '0;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi_req_sched #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
    .inst_error(inst_error),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok), .data_error(data_error),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          st, ld, fe, fc, hold_fe, pregranted;
    logic [31:0] ia, da, wd, rd;
    logic [3:0]  ws;
    logic [1:0]  resp;
    int          d_a, d_w, d_r, cancel_at;
  } txn_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  function automatic txn_t blank_txn();
    txn_t t;
    t.st = 0; t.ld = 0; t.fe = 0; t.fc = 0; t.hold_fe = 0; t.pregranted = 0;
    t.ia = '0; t.da = '0; t.wd = '0; t.rd = '0; t.ws = '0; t.resp = '0;
    t.d_a = 0; t.d_w = 0; t.d_r = 0; t.cancel_at = -1;
    return t;
  endfunction

  // Model: priority store > load > fetch; per-cycle channel expectations derived from slave delays.
  task automatic xact(input txn_t t);
    int          win, ca, cr, caw, cw, ce, cb, cp, last;
    bit          is_rd, drop, pulse_i, pulse_d;
    logic [31:0] exp_addr;
    win = t.st ? 1 : t.ld ? 2 : (t.fe && !t.fc) ? 3 : 0;
    is_rd = (win != 1);
    exp_addr = (win == 3) ? t.ia : t.da;
    ca = 0; cr = 0; caw = 0; cw = 0; ce = 0; cb = 0;
    if (is_rd) begin
      ca = 1 + t.d_a; cr = ca + 1 + t.d_r; cp = cr + 1;
    end else begin
      caw = 1 + t.d_a; cw = 1 + t.d_w; ce = ((caw > cw) ? caw : cw) + 1; cb = ce + t.d_r; cp = cb + 1;
    end
    drop = (win == 3) && t.cancel_at >= 1 && t.cancel_at < cp;
    last = t.hold_fe ? cp : cp + 1;
    if (!t.pregranted) begin
      tick();
      inst_req = t.fe; inst_addr = t.ia; inst_cancel = t.fc;
      data_req = t.st | t.ld; data_wr = t.st; data_addr = t.da; data_wdata = t.wd; data_wstrb = t.ws;
      #1;
      check("grant_data", data_addr_ok, (win == 1 || win == 2));
      check("grant_inst", inst_addr_ok, (win == 3));
      if (win == 0) begin
        inst_req = 0; data_req = 0; inst_cancel = 0;
        return;
      end
    end
    for (int c = 1; c <= last; c++) begin
      tick();
      inst_req = t.hold_fe; data_req = 0; inst_cancel = (c == t.cancel_at);
      arready = is_rd && (c == ca);
      rvalid  = is_rd && (c == cr);
      rdata   = (c == cr) ? t.rd : $urandom;
      rresp   = (c == cr) ? t.resp : 2'($urandom);
      awready = !is_rd && (c == caw);
      wready  = !is_rd && (c == cw);
      bvalid  = !is_rd && (c == cb);
      bresp   = (c == cb) ? t.resp : 2'($urandom);
      #1;
      check($sformatf("arvalid@%0d", c), arvalid, is_rd && c <= ca);
      if (is_rd && c <= ca) check($sformatf("araddr@%0d", c), araddr, exp_addr);
      check($sformatf("rready@%0d", c), rready, is_rd && c > ca && c <= cr);
      check($sformatf("awvalid@%0d", c), awvalid, !is_rd && c <= caw);
      if (!is_rd && c <= caw) check($sformatf("awaddr@%0d", c), awaddr, exp_addr);
      check($sformatf("wvalid@%0d", c), wvalid, !is_rd && c <= cw);
      if (!is_rd && c <= cw) check($sformatf("wdata@%0d", c), {wstrb, wdata}, {t.ws, t.wd});
      check($sformatf("bready@%0d", c), bready, !is_rd && c >= ce && c <= cb);
      check($sformatf("inst_addr_ok@%0d", c), inst_addr_ok, t.hold_fe && c == cp);
      check($sformatf("data_addr_ok@%0d", c), data_addr_ok, 1'b0);
      pulse_i = (c == cp) && (win == 3) && !drop;
      pulse_d = (c == cp) && (win != 3);
      check($sformatf("inst_valid@%0d", c), inst_valid, pulse_i);
      check($sformatf("inst_rdata@%0d", c), {inst_error, inst_rdata},
            pulse_i ? {(t.resp != 2'b00), t.rd} : 33'h0);
      check($sformatf("data_data_ok@%0d", c), data_data_ok, pulse_d);
      check($sformatf("data_rdata@%0d", c), {data_error, data_rdata},
            pulse_d ? {(t.resp != 2'b00), (win == 2) ? t.rd : 32'h0} : 33'h0);
    end
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; inst_cancel = 0;
  endtask

  initial begin
    txn_t t;
    int   n;
    bit   exp_f, prev_f;

    // Reset state
    tick();
    #1;
    check("reset_outs", |{inst_addr_ok, inst_valid, inst_rdata, inst_error, data_addr_ok,
                          data_rdata, data_data_ok, data_error, araddr, arvalid, rready,
                          awaddr, awvalid, wdata, wstrb, wvalid, bready}, 1'b0);
    areset = 0;

    // 1: minimum-latency fetch
    t = blank_txn(); t.fe = 1; t.ia = 32'h1C00_0000; t.rd = 32'hDEAD_BEEF;
    xact(t);

    // 2: fetch and load together; load wins, fetch granted on the load's response cycle
    t = blank_txn(); t.ld = 1; t.fe = 1; t.hold_fe = 1; t.ia = 32'h1C00_0000; t.da = 32'h100;
    t.rd = 32'h0BAD_F00D; t.d_r = 1;
    xact(t);
    t = blank_txn(); t.fe = 1; t.pregranted = 1; t.ia = 32'h1C00_0000; t.rd = 32'h5555_AAAA;
    xact(t);

    // 3: store, W before AW, SLVERR response
    t = blank_txn(); t.st = 1; t.da = 32'h200; t.wd = 32'h1234_5678; t.ws = 4'hF;
    t.d_a = 2; t.d_w = 0; t.resp = 2'd2;
    xact(t);

    // 4: cancel during RD_DATA swallows the response; next fetch is normal
    t = blank_txn(); t.fe = 1; t.ia = 32'h1C00_0000; t.rd = 32'h1111_2222; t.d_r = 2; t.cancel_at = 2;
    xact(t);
    t = blank_txn(); t.fe = 1; t.ia = 32'h1C00_0004; t.rd = 32'h3333_4444; t.resp = 2'd3;
    xact(t);

    // Fetch cancelled on the request cycle with nothing else pending: no grant
    t = blank_txn(); t.fe = 1; t.fc = 1; t.ia = 32'h1C00_0008;
    xact(t);

    // 5: reset while waiting in RD_DATA, then a late rvalid
    tick();
    inst_req = 1; inst_addr = 32'h1C00_0200;
    #1; check("rst5_grant", inst_addr_ok, 1'b1);
    tick(); inst_req = 0; arready = 1;
    tick(); arready = 0;
    #1; check("rst5_rready_before", rready, 1'b1);
    areset = 1;
    #1;
    check("rst5_outs", |{inst_addr_ok, inst_valid, inst_rdata, inst_error, data_addr_ok,
                         data_rdata, data_data_ok, data_error, araddr, arvalid, rready,
                         awaddr, awvalid, wdata, wstrb, wvalid, bready}, 1'b0);
    tick(); areset = 0; rvalid = 1; rdata = 32'hFEED_FACE;
    #1; check("rst5_no_rready", {rready, arvalid, awvalid, wvalid, bready}, 5'b0);
    tick(); rvalid = 0;
    #1; check("rst5_no_pulse", {inst_valid, data_data_ok}, 2'b0);
    t = blank_txn(); t.ld = 1; t.da = 32'h400; t.rd = 32'h7777_8888; t.d_a = 1;
    xact(t);

    // 6: back-to-back loads with fetch held pending
    tick();
    data_req = 1; data_wr = 0; data_addr = 32'h100; inst_req = 1; inst_addr = 32'h1C00_0100;
    n = 0; prev_f = 0;
    for (int g = 0; g <= 6; g++) begin
      if (g == 6) begin data_req = 0; inst_req = 0; end
      #1;
      if (g > 0) begin
        check($sformatf("starve_ivalid%0d", g), inst_valid, prev_f);
        check($sformatf("starve_dok%0d", g), data_data_ok, !prev_f);
        check($sformatf("starve_rdata%0d", g), prev_f ? inst_rdata : data_rdata, 32'hA000_0000 + g - 1);
      end
      if (g < 6) begin
        exp_f = STARVE_GUARD && (n == STARVE_MAX);
        check($sformatf("starve_inst_ok%0d", g), inst_addr_ok, exp_f);
        check($sformatf("starve_data_ok%0d", g), data_addr_ok, !exp_f);
        n = exp_f ? 0 : n + 1;
        prev_f = exp_f;
        tick(); arready = 1;
        tick(); arready = 0; rvalid = 1; rdata = 32'hA000_0000 + g; rresp = 0;
        tick(); rvalid = 0;
      end
    end

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      t = blank_txn();
      t.st = ($urandom_range(0, 3) == 0);
      t.ld = ($urandom_range(0, 2) == 0);
      t.fe = ($urandom_range(0, 1) == 1);
      t.fc = ($urandom_range(0, 4) == 0);
      t.ia = $urandom; t.da = $urandom; t.wd = $urandom; t.rd = $urandom;
      t.ws = 4'($urandom); t.resp = 2'($urandom);
      t.d_a = $urandom_range(0, 3); t.d_w = $urandom_range(0, 3); t.d_r = $urandom_range(0, 3);
      t.cancel_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : -1;
      xact(t);
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
